ahb5_rr_arbiter: RTL

// Shares one downstream AHB5 path (AHB5-to-APB4 bridge) between NUM_AHB upstream random-transaction masters.

---
 rtl/ahb5_rr_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb5_rr_arbiter.sv
// rtl/ahb5_rr_arbiter.sv - round-robin sharing of one downstream AHB5 path between NUM_AHB masters
// Each master's address phase is held per port; one single transfer is outstanding downstream at a time.
module ahb5_rr_arbiter #(
  parameter  int NUM_AHB = 2,
  localparam int IDW     = $clog2(NUM_AHB)
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NUM_AHB-1:0]       S_HSEL,
  input  logic [NUM_AHB-1:0][1:0]  S_HTRANS,
  input  logic [NUM_AHB-1:0][31:0] S_HADDR,
  input  logic [NUM_AHB-1:0]       S_HWRITE,
  input  logic [NUM_AHB-1:0][2:0]  S_HSIZE,
  input  logic [NUM_AHB-1:0]       S_HMASTLOCK,
  input  logic [NUM_AHB-1:0]       S_HNONSEC,
  input  logic [NUM_AHB-1:0][31:0] S_HWDATA,
  output logic [NUM_AHB-1:0]       S_HREADYOUT,
  output logic [NUM_AHB-1:0][31:0] S_HRDATA,
  output logic [NUM_AHB-1:0]       S_HRESP,
  output logic [1:0]               M_HTRANS,
  output logic [31:0]              M_HADDR,
  output logic                     M_HWRITE,
  output logic [2:0]               M_HSIZE,
  output logic                     M_HMASTLOCK,
  output logic                     M_HNONSEC,
  output logic [31:0]              M_HWDATA,
  input  logic                     M_HREADY,
  input  logic [31:0]              M_HRDATA,
  input  logic                     M_HRESP,
  output logic [IDW-1:0]           GRANT_ID
);

  typedef enum logic [1:0] {P_IDLE, P_PEND, P_ACT} pst_t;
  typedef enum logic [1:0] {A_IDLE, A_ADDR, A_DATA} ast_t;

  localparam logic [IDW:0] NUM_W = (IDW+1)'(NUM_AHB);

  pst_t        pst_q     [NUM_AHB];
  pst_t        pst_d     [NUM_AHB];
  logic [31:0] haddr_q   [NUM_AHB];
  logic [31:0] haddr_d   [NUM_AHB];
  logic        hwrite_q  [NUM_AHB];
  logic        hwrite_d  [NUM_AHB];
  logic [2:0]  hsize_q   [NUM_AHB];
  logic [2:0]  hsize_d   [NUM_AHB];
  logic        hlock_q   [NUM_AHB];
  logic        hlock_d   [NUM_AHB];
  logic        hnonsec_q [NUM_AHB];
  logic        hnonsec_d [NUM_AHB];

  ast_t           ast_q, ast_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] lock_own_q, lock_own_d;
  logic           lock_q, lock_d;

  logic [NUM_AHB-1:0] req, pend, elig, own_mask;
  logic               done, found, grant_now, capture;
  logic [IDW-1:0]     winner;
  logic [IDW:0]       scan;

  assign done     = (ast_q == A_DATA) && M_HREADY;
  assign GRANT_ID = grant_q;

  always_comb begin
    for (int i = 0; i < NUM_AHB; i++) begin
      req[i]  = S_HSEL[i] & S_HTRANS[i][1];
      pend[i] = (pst_q[i] == P_PEND);
    end

    // Lock state is resolved first so a lock taken on this edge already filters the next grant.
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    if (done && hlock_q[grant_q]) begin
      lock_d     = 1'b1;
      lock_own_d = grant_q;
    end else if (lock_q && done && (grant_q == lock_own_q)) begin
      lock_d = 1'b0;
    end else if (lock_q && (pst_q[lock_own_q] == P_IDLE) && !req[lock_own_q]) begin
      lock_d = 1'b0;
    end

    own_mask             = '0;
    own_mask[lock_own_d] = 1'b1;
    elig                 = lock_d ? (pend & own_mask) : pend;

    found  = 1'b0;
    winner = ptr_q;
    scan   = '0;
    for (int k = 1; k <= NUM_AHB; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= NUM_W) scan = scan - NUM_W;
      if (!found && elig[scan[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IDW-1:0];
      end
    end

    ast_d     = ast_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    grant_now = 1'b0;
    case (ast_q)
      A_IDLE:  grant_now = found;
      A_ADDR:  ast_d = A_DATA;
      A_DATA:  if (M_HREADY) begin
                 if (found) grant_now = 1'b1;
                 else       ast_d     = A_IDLE;
               end
      default: ast_d = A_IDLE;
    endcase
    if (grant_now) begin
      ast_d   = A_ADDR;
      grant_d = winner;
      if (!lock_d) ptr_d = winner;
    end

    capture = 1'b0;
    for (int i = 0; i < NUM_AHB; i++) begin
      pst_d[i]     = pst_q[i];
      haddr_d[i]   = haddr_q[i];
      hwrite_d[i]  = hwrite_q[i];
      hsize_d[i]   = hsize_q[i];
      hlock_d[i]   = hlock_q[i];
      hnonsec_d[i] = hnonsec_q[i];
      capture      = 1'b0;
      case (pst_q[i])
        P_IDLE:  capture = req[i];
        P_PEND:  if (grant_now && (winner == IDW'(i))) pst_d[i] = P_ACT;
        P_ACT:   if (done) begin
                   pst_d[i] = P_IDLE;
                   capture  = req[i];
                 end
        default: pst_d[i] = P_IDLE;
      endcase
      if (capture) begin
        pst_d[i]     = P_PEND;
        haddr_d[i]   = S_HADDR[i];
        hwrite_d[i]  = S_HWRITE[i];
        hsize_d[i]   = S_HSIZE[i];
        hlock_d[i]   = S_HMASTLOCK[i];
        hnonsec_d[i] = S_HNONSEC[i];
      end
    end
  end

  always_comb begin
    S_HREADYOUT = '1;
    S_HRESP     = '0;
    S_HRDATA    = '0;
    for (int i = 0; i < NUM_AHB; i++) begin
      if (pst_q[i] != P_IDLE) S_HREADYOUT[i] = 1'b0;
    end
    if (ast_q == A_DATA) begin
      S_HREADYOUT[grant_q] = M_HREADY;
      S_HRESP[grant_q]     = M_HRESP;
      S_HRDATA[grant_q]    = M_HRDATA;
    end

    M_HTRANS    = 2'b00;
    M_HADDR     = '0;
    M_HWRITE    = 1'b0;
    M_HSIZE     = '0;
    M_HMASTLOCK = 1'b0;
    M_HNONSEC   = 1'b0;
    M_HWDATA    = '0;
    if (ast_q == A_ADDR) begin
      M_HTRANS    = 2'b10;
      M_HADDR     = haddr_q[grant_q];
      M_HWRITE    = hwrite_q[grant_q];
      M_HSIZE     = hsize_q[grant_q];
      M_HMASTLOCK = hlock_q[grant_q];
      M_HNONSEC   = hnonsec_q[grant_q];
    end
    if (ast_q == A_DATA) M_HWDATA = S_HWDATA[grant_q];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ast_q      <= A_IDLE;
      grant_q    <= '0;
      ptr_q      <= IDW'(NUM_AHB - 1);
      lock_q     <= 1'b0;
      lock_own_q <= '0;
      for (int i = 0; i < NUM_AHB; i++) begin
        pst_q[i]     <= P_IDLE;
        haddr_q[i]   <= '0;
        hwrite_q[i]  <= 1'b0;
        hsize_q[i]   <= '0;
        hlock_q[i]   <= 1'b0;
        hnonsec_q[i] <= 1'b0;
      end
    end else begin
      ast_q      <= ast_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      for (int i = 0; i < NUM_AHB; i++) begin
        pst_q[i]     <= pst_d[i];
        haddr_q[i]   <= haddr_d[i];
        hwrite_q[i]  <= hwrite_d[i];
        hsize_q[i]   <= hsize_d[i];
        hlock_q[i]   <= hlock_d[i];
        hnonsec_q[i] <= hnonsec_d[i];
      end
    end
  end

endmodule
